mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage LoongArch pipeline.
// Registers the execute-stage bus, waits for the data-SRAM response of an
// in-flight load, extracts and extends the loaded byte/halfword/word, and hands
// the completed instruction to write-back over a valid/allowin handshake.
// It also drives a forwarding/interlock bus back to decode.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   ws_allowin         wb stage can accept this cycle
//   ms_allowin         this stage can accept this cycle
//   es_to_ms_valid/bus execute-stage instruction:
//                      {res_from_mem, ld_type[2:0], gr_we, dest[4:0], alu_result, pc}
//   ms_to_ws_valid/bus completed instruction: {gr_we, dest, final_result, pc}
//   ms_to_ds_bus       forwarding: {fwd_we, fwd_blocking, fwd_dest, fwd_data}
//   data_sram_data_ok  read data of the outstanding load is valid
//   data_sram_rdata    read data
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39,
  parameter int DATA_W          = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [DATA_W-1:0]          data_sram_rdata
);

  // Extract the addressed byte/halfword and extend it. ld_type 101-111 fall
  // back to a whole-word load; addr[0] is ignored for halfwords.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [2:0]        ld_type,
    input logic [1:0]        addr,
    input logic [DATA_W-1:0] rdata
  );
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [DATA_W-1:0]  res;
    case (addr)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      3'b001:  res = DATA_W'(byte_s);
      3'b010:  res = DATA_W'(half_s);
      3'b011:  res = {24'd0, byte_s};
      3'b100:  res = {16'd0, half_s};
      default: res = rdata;
    endcase
    return res;
  endfunction

  logic                       vld_p0;
  logic [ES_TO_MS_BUS_WD-1:0] bus_p0;
  logic                       buf_vld_p0;
  logic [DATA_W-1:0]          buf_data_p0;

  logic              res_from_mem;
  logic [2:0]        ld_type;
  logic              gr_we;
  logic [4:0]        dest;
  logic [DATA_W-1:0] alu_result;
  logic [31:0]       pc;
  logic              ms_ready_go;
  logic              buf_capture;
  logic [DATA_W-1:0] eff_rdata;
  logic [DATA_W-1:0] final_result;

  assign res_from_mem = bus_p0[73];
  assign ld_type      = bus_p0[72:70];
  assign gr_we        = bus_p0[69];
  assign dest         = bus_p0[68:64];
  assign alu_result   = bus_p0[63:32];
  assign pc           = bus_p0[31:0];

  assign ms_ready_go    = !res_from_mem || data_sram_data_ok || buf_vld_p0;
  assign ms_allowin     = !vld_p0 || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = vld_p0 && ms_ready_go;

  // Data arriving while wb is stalled must be held: the SRAM presents it for
  // one cycle only. Later data_ok pulses are ignored once the buffer is full.
  assign buf_capture = vld_p0 && res_from_mem && data_sram_data_ok &&
                       !ws_allowin && !buf_vld_p0;

  assign eff_rdata    = buf_vld_p0 ? buf_data_p0 : data_sram_rdata;
  assign final_result = res_from_mem ? load_extract(ld_type, alu_result[1:0], eff_rdata)
                                     : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {vld_p0 && gr_we,
                         vld_p0 && res_from_mem && !ms_ready_go,
                         dest, final_result};

  // Stage p0: instruction register and load-data buffer control.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p0     <= 1'b0;
      bus_p0     <= '0;
      buf_vld_p0 <= 1'b0;
    end else begin
      if (ms_allowin) vld_p0 <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) bus_p0 <= es_to_ms_bus;
      if (ms_to_ws_valid && ws_allowin) buf_vld_p0 <= 1'b0;
      else if (buf_capture)             buf_vld_p0 <= 1'b1;
    end
  end

  // Buffered read data; meaningful only while buf_vld_p0 is set.
  always_ff @(posedge clk) begin
    if (buf_capture) buf_data_p0 <= data_sram_rdata;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int passed = 0;
  int total  = 0;
  logic [69:0] exp_q[$];

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [73:0] mkbus(input logic rfm, input logic [2:0] ldt,
                                        input logic we, input logic [4:0] dst,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {rfm, ldt, we, dst, alu, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard monitor: every transfer to wb pops one expected bus.
  always @(negedge clk) begin
    if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_retire: got %h expected none", ms_to_ws_bus);
      end else begin
        chk("retire_bus", ms_to_ws_bus, exp_q.pop_front());
      end
    end
  end

  // Load entering with data_ok in its first cycle.
  task automatic do_load(input string name, input logic [2:0] ldt, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] expv, input logic [31:0] pc);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mkbus(1'b1, ldt, 1'b1, 5'd7, addr, pc);
    exp_q.push_back({1'b1, 5'd7, expv, pc});
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    settle();
    chk({name, "_valid"}, 70'(ms_to_ws_valid), 70'(1));
    chk({name, "_fwd_data"}, 70'(ms_to_ds_bus[31:0]), 70'(expv));
    step();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (3) step();
    resetn = 1'b1;
    settle();
    chk("rst_allowin", 70'(ms_allowin), 70'(1));
    chk("rst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_ws_bus", ms_to_ws_bus, 70'(0));
    chk("rst_ds_bus", 70'(ms_to_ds_bus), 70'(0));

    // Non-load add
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mkbus(1'b0, 3'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000);
    exp_q.push_back({1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000});
    step();
    es_to_ms_valid = 1'b0;
    settle();
    chk("add_valid", 70'(ms_to_ws_valid), 70'(1));
    chk("add_fwd_we", 70'(ms_to_ds_bus[38]), 70'(1));
    chk("add_fwd_data", 70'(ms_to_ds_bus[31:0]), 70'(32'h1234));
    step();

    // ld.b with data three cycles after entry
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mkbus(1'b1, 3'b001, 1'b1, 5'd6, 32'h0000_1003, 32'h1c00_0004);
    exp_q.push_back({1'b1, 5'd6, 32'hFFFF_FF80, 32'h1c00_0004});
    step();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ldb_wait_blocking", 70'(ms_to_ds_bus[37]), 70'(1));
      chk("ldb_wait_allowin", 70'(ms_allowin), 70'(0));
      chk("ldb_wait_valid", 70'(ms_to_ws_valid), 70'(0));
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80AA_BBCC;
    settle();
    chk("ldb_valid", 70'(ms_to_ws_valid), 70'(1));
    chk("ldb_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_FF80));
    chk("ldb_unblock", 70'(ms_to_ds_bus[37]), 70'(0));
    step();
    data_sram_data_ok = 1'b0;

    // Extraction variants
    do_load("ldhu", 3'b100, 32'h2002, 32'h8001_7FFF, 32'h0000_8001, 32'h1c00_0010);
    do_load("ldh",  3'b010, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001, 32'h1c00_0014);
    do_load("ldbu", 3'b011, 32'h2001, 32'h8001_7FFF, 32'h0000_007F, 32'h1c00_0018);
    do_load("ldw",  3'b000, 32'h2000, 32'h8001_7FFF, 32'h8001_7FFF, 32'h1c00_001c);

    // ld.w with wb stalled: data buffered, stray data_ok ignored
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mkbus(1'b1, 3'b000, 1'b1, 5'd9, 32'h0000_3000, 32'h1c00_0020);
    exp_q.push_back({1'b1, 5'd9, 32'hDEAD_BEEF, 32'h1c00_0020});
    step();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("stall_valid", 70'(ms_to_ws_valid), 70'(1));
    chk("stall_allowin", 70'(ms_allowin), 70'(0));
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0;
    settle();
    chk("stall_hold_data", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
    chk("stall_hold_valid", 70'(ms_to_ws_valid), 70'(1));
    step();
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'b1;
    settle();
    chk("stall_release_data", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
    step();
    settle();
    chk("stall_left", 70'(ms_to_ws_valid), 70'(0));

    // Back-to-back non-loads
    for (int k = 0; k < 4; k++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mkbus(1'b0, 3'd0, 1'b1, 5'(k + 1), 32'(16 + k), 32'(32'h100 + 4 * k));
      exp_q.push_back({1'b1, 5'(k + 1), 32'(16 + k), 32'(32'h100 + 4 * k)});
      settle();
      chk("stream_allowin", 70'(ms_allowin), 70'(1));
      if (k > 0) chk("stream_valid", 70'(ms_to_ws_valid), 70'(1));
      step();
    end
    es_to_ms_valid = 1'b0;
    settle();
    chk("stream_last_valid", 70'(ms_to_ws_valid), 70'(1));
    step();
    settle();
    chk("stream_empty", 70'(ms_to_ws_valid), 70'(0));

    // Reset during a load's wait
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mkbus(1'b1, 3'b000, 1'b1, 5'd3, 32'h0000_4000, 32'h1c00_0040);
    step();
    es_to_ms_valid = 1'b0;
    settle();
    chk("rstload_blocking", 70'(ms_to_ds_bus[37]), 70'(1));
    resetn = 1'b0;
    step();
    resetn            = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    settle();
    chk("rstload_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rstload_ds_bus", 70'(ms_to_ds_bus), 70'(0));
    chk("rstload_allowin", 70'(ms_allowin), 70'(1));
    step();
    data_sram_data_ok = 1'b0;
    settle();
    chk("rstload_empty", 70'(ms_to_ws_valid), 70'(0));
    step();

    chk("queue_drained", 70'(exp_q.size()), 70'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
